// File: rtl/bvh_traversal_ctrl_if.sv
// Signal bundle joining the BVH traversal controller to ray setup, node memory,
// the combinational slab tester and the triangle stage; master = controller side.
interface bvh_traversal_ctrl_if #(
  parameter int NODE_AW = 10
);
  typedef struct packed {
    logic signed [23:0] x;
    logic signed [23:0] y;
    logic signed [23:0] z;
  } vec3_t;

  typedef struct packed {
    logic signed [23:0] tmin;
    logic signed [23:0] tmax;
  } vec2_t;

  typedef struct packed {
    vec3_t lo;
    vec3_t hi;
  } bbox_t;

  logic               ray_valid;
  logic               ray_ready;
  vec3_t              ray_orig;
  vec3_t              inv_ray_dir;
  vec2_t              t_range;

  vec3_t              isect_orig;
  vec3_t              isect_inv_dir;
  bbox_t              isect_box;
  vec2_t              isect_range;
  logic               isect_hit;
  vec2_t              isect_range_out;

  logic               node_req;
  logic [NODE_AW-1:0] node_addr;
  logic               node_rvalid;
  bbox_t              node_box;
  logic               node_leaf;
  logic [NODE_AW-1:0] node_child;
  logic [15:0]        node_prim_base;
  logic [3:0]         node_prim_cnt;

  logic               leaf_valid;
  logic               leaf_ready;
  logic [15:0]        leaf_prim_base;
  logic [3:0]         leaf_prim_cnt;
  vec2_t              leaf_range;

  logic               done;
  logic               overflow;

  modport master (
    input  ray_valid, ray_orig, inv_ray_dir, t_range,
    output ray_ready,
    output isect_orig, isect_inv_dir, isect_box, isect_range,
    input  isect_hit, isect_range_out,
    output node_req, node_addr,
    input  node_rvalid, node_box, node_leaf, node_child, node_prim_base, node_prim_cnt,
    output leaf_valid, leaf_prim_base, leaf_prim_cnt, leaf_range,
    input  leaf_ready,
    output done, overflow
  );

  modport slave (
    output ray_valid, ray_orig, inv_ray_dir, t_range,
    input  ray_ready,
    input  isect_orig, isect_inv_dir, isect_box, isect_range,
    output isect_hit, isect_range_out,
    input  node_req, node_addr,
    output node_rvalid, node_box, node_leaf, node_child, node_prim_base, node_prim_cnt,
    input  leaf_valid, leaf_prim_base, leaf_prim_cnt, leaf_range,
    output leaf_ready,
    input  done, overflow
  );
endinterface

// File: rtl/bvh_traversal_ctrl.sv
// Depth-first BVH walker for one ray at a time; root miss with 1-cycle memory finishes 6 cycles after accept.
// Backpressure: new rays only in IDLE; leaf outputs held stable until leaf_ready; waits indefinitely on node_rvalid.
module bvh_traversal_ctrl #(
  parameter int NODE_AW     = 10,
  parameter int STACK_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bvh_traversal_ctrl_if.master bus
);
  localparam int SIW = $clog2(STACK_DEPTH);
  localparam int SPW = SIW + 1;

  typedef struct packed {
    logic signed [23:0] x;
    logic signed [23:0] y;
    logic signed [23:0] z;
  } vec3_t;

  typedef struct packed {
    logic signed [23:0] tmin;
    logic signed [23:0] tmax;
  } vec2_t;

  typedef struct packed {
    vec3_t lo;
    vec3_t hi;
  } bbox_t;

  typedef struct packed {
    logic [NODE_AW-1:0] node;
    vec2_t              range;
  } stk_ent_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_TEST, S_DECIDE, S_EMIT, S_POP, S_DONE
  } state_t;

  state_t             state_q, state_d;
  vec3_t              orig_q, inv_q;
  bbox_t              box_q;
  vec2_t              cur_range_q, hit_range_q;
  logic [NODE_AW-1:0] cur_node_q, child_q;
  logic               leaf_q, hit_q, overflow_q;
  logic [15:0]        prim_base_q;
  logic [3:0]         prim_cnt_q;
  logic [SPW-1:0]     sp_q;
  stk_ent_t           stack_mem [STACK_DEPTH];

  logic               stack_full, stack_empty, descend, push_en;
  logic               ray_ready_c, node_req_c, leaf_valid_c, done_c;
  stk_ent_t           stack_top;

  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign stack_top   = stack_mem[SIW'(sp_q - 1'b1)];
  assign descend     = (state_q == S_DECIDE) && hit_q && !leaf_q;
  // A full stack drops the right child but the left descent still proceeds.
  assign push_en     = descend && !stack_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ray_ready_c  = 1'b0;
    node_req_c   = 1'b0;
    leaf_valid_c = 1'b0;
    done_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        ray_ready_c = 1'b1;
        if (bus.ray_valid) state_d = S_FETCH;
      end
      S_FETCH: begin
        node_req_c = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT:   if (bus.node_rvalid) state_d = S_TEST;
      S_TEST:   state_d = S_DECIDE;
      S_DECIDE: begin
        if (!hit_q)      state_d = S_POP;
        else if (leaf_q) state_d = S_EMIT;
        else             state_d = S_FETCH;
      end
      S_EMIT: begin
        leaf_valid_c = 1'b1;
        if (bus.leaf_ready) state_d = S_POP;
      end
      S_POP:    state_d = stack_empty ? S_DONE : S_FETCH;
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig_q      <= '0;
      inv_q       <= '0;
      box_q       <= '0;
      cur_range_q <= '0;
      hit_range_q <= '0;
      cur_node_q  <= '0;
      child_q     <= '0;
      leaf_q      <= 1'b0;
      hit_q       <= 1'b0;
      overflow_q  <= 1'b0;
      prim_base_q <= '0;
      prim_cnt_q  <= '0;
      sp_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.ray_valid) begin
          orig_q      <= bus.ray_orig;
          inv_q       <= bus.inv_ray_dir;
          cur_range_q <= bus.t_range;
          cur_node_q  <= '0;
          overflow_q  <= 1'b0;
        end
        S_WAIT: if (bus.node_rvalid) begin
          box_q       <= bus.node_box;
          leaf_q      <= bus.node_leaf;
          child_q     <= bus.node_child;
          prim_base_q <= bus.node_prim_base;
          prim_cnt_q  <= bus.node_prim_cnt;
        end
        S_TEST: begin
          hit_q       <= bus.isect_hit;
          hit_range_q <= bus.isect_range_out;
        end
        S_DECIDE: if (descend) begin
          cur_node_q  <= child_q;
          cur_range_q <= hit_range_q;
          if (stack_full) overflow_q <= 1'b1;
          else            sp_q       <= sp_q + 1'b1;
        end
        S_POP: if (!stack_empty) begin
          cur_node_q  <= stack_top.node;
          cur_range_q <= stack_top.range;
          sp_q        <= sp_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Entries past sp_q are dead, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[SIW'(sp_q)].node  <= NODE_AW'(child_q + 1'b1);
      stack_mem[SIW'(sp_q)].range <= hit_range_q;
    end
  end

  assign bus.ray_ready      = ray_ready_c;
  assign bus.node_req       = node_req_c;
  assign bus.node_addr      = cur_node_q;
  assign bus.isect_orig     = orig_q;
  assign bus.isect_inv_dir  = inv_q;
  assign bus.isect_box      = box_q;
  assign bus.isect_range    = cur_range_q;
  assign bus.leaf_valid     = leaf_valid_c;
  assign bus.leaf_prim_base = prim_base_q;
  assign bus.leaf_prim_cnt  = prim_cnt_q;
  assign bus.leaf_range     = hit_range_q;
  assign bus.done           = done_c;
  assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_bvh_traversal_ctrl.sv
// Randomized bench for bvh_traversal_ctrl: node memory, slab unit and triangle stage are
// modelled here, and every ray is compared against a queue-based depth-first traversal model.
module tb_bvh_traversal_ctrl;
  localparam int NODE_AW = 10;
  localparam int SD      = 2;
  localparam int NN      = 1 << NODE_AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bvh_traversal_ctrl_if #(.NODE_AW(NODE_AW)) bus ();

  bvh_traversal_ctrl #(.NODE_AW(NODE_AW), .STACK_DEPTH(SD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int m_lo [NN][3];
  int m_hi [NN][3];
  bit m_leaf [NN];
  int m_child [NN];
  int m_base [NN];
  int m_cnt [NN];
  int r_org [3];
  int r_inv [3];
  int r_t0, r_t1;

  int exp_addr[$], exp_base[$], exp_cnt[$], exp_r0[$], exp_r1[$];
  int got_addr[$], got_base[$], got_cnt[$], got_r0[$], got_r1[$];
  bit exp_ov;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void slab_axis(input int lo, input int hi, input int o, input int iv,
                                    inout int tn, inout int tf);
    int a, b, t;
    a = (lo - o) * iv;
    b = (hi - o) * iv;
    if (a > b) begin t = a; a = b; b = t; end
    if (a > tn) tn = a;
    if (b < tf) tf = b;
  endfunction

  // Slab tester: purely combinational on the controller's isect_* outputs.
  always_comb begin : slab_unit
    int tn, tf;
    tn = int'(bus.isect_range.tmin);
    tf = int'(bus.isect_range.tmax);
    slab_axis(int'(bus.isect_box.lo.x), int'(bus.isect_box.hi.x), int'(bus.isect_orig.x), int'(bus.isect_inv_dir.x), tn, tf);
    slab_axis(int'(bus.isect_box.lo.y), int'(bus.isect_box.hi.y), int'(bus.isect_orig.y), int'(bus.isect_inv_dir.y), tn, tf);
    slab_axis(int'(bus.isect_box.lo.z), int'(bus.isect_box.hi.z), int'(bus.isect_orig.z), int'(bus.isect_inv_dir.z), tn, tf);
    bus.isect_hit            = (tn <= tf);
    bus.isect_range_out.tmin = 24'(tn);
    bus.isect_range_out.tmax = 24'(tf);
  end

  task automatic clear_tree();
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < 3; a++) begin m_lo[n][a] = 100; m_hi[n][a] = 101; end
      m_leaf[n] = 1'b1; m_child[n] = 0; m_base[n] = 0; m_cnt[n] = 0;
    end
  endtask

  task automatic set_node(input int n, input bit leaf, input int child, input int lo, input int hi,
                          input int base, input int cnt);
    for (int a = 0; a < 3; a++) begin m_lo[n][a] = lo; m_hi[n][a] = hi; end
    m_leaf[n] = leaf; m_child[n] = child; m_base[n] = base; m_cnt[n] = cnt;
  endtask

  task automatic set_ray(input int o, input int iv, input int t0, input int t1);
    for (int a = 0; a < 3; a++) begin r_org[a] = o; r_inv[a] = iv; end
    r_t0 = t0; r_t1 = t1;
  endtask

  task automatic build_tree(input int maxd);
    int wn[$], wd[$];
    int n, d, nxt;
    nxt = 1;
    wn.push_back(0); wd.push_back(0);
    while (wn.size() > 0) begin
      n = wn.pop_front(); d = wd.pop_front();
      for (int a = 0; a < 3; a++) begin
        m_lo[n][a] = int'($urandom_range(0, 9));
        m_hi[n][a] = m_lo[n][a] + int'($urandom_range(0, 6));
      end
      m_base[n] = int'($urandom_range(0, 65535));
      m_cnt[n]  = int'($urandom_range(0, 15));
      if (d < maxd && $urandom_range(0, 3) != 0) begin
        m_leaf[n] = 1'b0; m_child[n] = nxt;
        wn.push_back(nxt); wn.push_back(nxt + 1);
        wd.push_back(d + 1); wd.push_back(d + 1);
        nxt += 2;
      end else begin
        m_leaf[n] = 1'b1; m_child[n] = int'($urandom_range(0, NN - 1));
      end
    end
  endtask

  // Reference: depth-first, left first, right child deferred on a bounded LIFO.
  task automatic model_ray();
    int sn[$], s0[$], s1[$];
    int cur, c0, c1, tn, tf, guard;
    bit fin;
    exp_addr.delete(); exp_base.delete(); exp_cnt.delete(); exp_r0.delete(); exp_r1.delete();
    exp_ov = 1'b0; cur = 0; c0 = r_t0; c1 = r_t1; fin = 1'b0; guard = 0;
    while (!fin && guard < 10000) begin
      guard++;
      exp_addr.push_back(cur);
      tn = c0; tf = c1;
      for (int a = 0; a < 3; a++) slab_axis(m_lo[cur][a], m_hi[cur][a], r_org[a], r_inv[a], tn, tf);
      if (tn <= tf && m_leaf[cur]) begin
        exp_base.push_back(m_base[cur]); exp_cnt.push_back(m_cnt[cur]);
        exp_r0.push_back(tn); exp_r1.push_back(tf);
      end
      if (tn <= tf && !m_leaf[cur]) begin
        if (sn.size() < SD) begin
          sn.push_back((m_child[cur] + 1) % NN); s0.push_back(tn); s1.push_back(tf);
        end else exp_ov = 1'b1;
        cur = m_child[cur]; c0 = tn; c1 = tf;
      end else if (sn.size() == 0) fin = 1'b1;
      else begin
        cur = sn.pop_back(); c0 = s0.pop_back(); c1 = s1.pop_back();
      end
    end
  endtask

  task automatic drive_ray();
    bus.ray_orig.x = 24'(r_org[0]);    bus.ray_orig.y = 24'(r_org[1]);    bus.ray_orig.z = 24'(r_org[2]);
    bus.inv_ray_dir.x = 24'(r_inv[0]); bus.inv_ray_dir.y = 24'(r_inv[1]); bus.inv_ray_dir.z = 24'(r_inv[2]);
    bus.t_range.tmin = 24'(r_t0);      bus.t_range.tmax = 24'(r_t1);
  endtask

  task automatic drive_node(input int a);
    bus.node_box.lo.x = 24'(m_lo[a][0]); bus.node_box.lo.y = 24'(m_lo[a][1]); bus.node_box.lo.z = 24'(m_lo[a][2]);
    bus.node_box.hi.x = 24'(m_hi[a][0]); bus.node_box.hi.y = 24'(m_hi[a][1]); bus.node_box.hi.z = 24'(m_hi[a][2]);
    bus.node_leaf      = m_leaf[a];
    bus.node_child     = NODE_AW'(m_child[a]);
    bus.node_prim_base = 16'(m_base[a]);
    bus.node_prim_cnt  = 4'(m_cnt[a]);
  endtask

  // Runs one ray to completion; hold<0 gives random leaf_ready, else leaf_ready rises after hold stall cycles.
  task automatic run_ray(input int lat, input int hold, input string tag, output int lat_done);
    int pend_a[$], pend_t[$];
    int start, vcnt, nreq, nrv, sv_b, sv_c, sv_r0, sv_r1, n;
    bit fin, stalled;
    got_addr.delete(); got_base.delete(); got_cnt.delete(); got_r0.delete(); got_r1.delete();
    model_ray();
    check({tag, ":ray_ready"}, bus.ray_ready, 1);
    drive_ray();
    bus.ray_valid = 1'b1;
    start = cyc;
    @(posedge clk); #1;
    bus.ray_valid = 1'b0;
    fin = 1'b0; stalled = 1'b0; vcnt = 0; nreq = 0; nrv = 0; lat_done = -1;
    sv_b = 0; sv_c = 0; sv_r0 = 0; sv_r1 = 0;
    while (!fin) begin
      if (pend_t.size() > 0 && pend_t[0] == cyc) begin
        drive_node(pend_a.pop_front());
        void'(pend_t.pop_front());
        bus.node_rvalid = 1'b1;
        nrv++;
      end else begin
        bus.node_rvalid = 1'b0;
        bus.node_leaf   = 1'($urandom_range(0, 1));
      end
      if (bus.node_req) begin
        got_addr.push_back(int'(bus.node_addr));
        pend_a.push_back(int'(bus.node_addr));
        pend_t.push_back(cyc + lat);
        nreq++;
      end
      if (bus.leaf_valid) begin
        if (stalled) begin
          check({tag, ":hold_base"}, bus.leaf_prim_base, sv_b);
          check({tag, ":hold_cnt"}, bus.leaf_prim_cnt, sv_c);
          check({tag, ":hold_r0"}, int'(bus.leaf_range.tmin), sv_r0);
          check({tag, ":hold_r1"}, int'(bus.leaf_range.tmax), sv_r1);
        end
        bus.leaf_ready = (hold < 0) ? 1'($urandom_range(0, 1)) : (vcnt >= hold);
        sv_b = int'(bus.leaf_prim_base); sv_c = int'(bus.leaf_prim_cnt);
        sv_r0 = int'(bus.leaf_range.tmin); sv_r1 = int'(bus.leaf_range.tmax);
        if (bus.leaf_ready) begin
          got_base.push_back(sv_b); got_cnt.push_back(sv_c);
          got_r0.push_back(sv_r0); got_r1.push_back(sv_r1);
          stalled = 1'b0; vcnt = 0;
        end else begin
          stalled = 1'b1; vcnt++;
        end
      end else begin
        bus.leaf_ready = 1'b0;
      end
      if (bus.done) begin
        lat_done = cyc - start;
        check({tag, ":overflow"}, bus.overflow, exp_ov);
        fin = 1'b1;
      end else if (cyc - start > 3000) begin
        check({tag, ":timeout"}, 0, 1);
        rst_n = 1'b0;
        fin = 1'b1;
      end
      if (!fin) begin @(posedge clk); #1; end
    end
    bus.node_rvalid = 1'b0;
    bus.leaf_ready  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check({tag, ":done_pulse"}, bus.done, 0);
    check({tag, ":ready_after"}, bus.ray_ready, 1);
    check({tag, ":req_vs_rvalid"}, nreq, nrv);
    check({tag, ":n_addr"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) check($sformatf("%s:addr%0d", tag, i), got_addr[i], exp_addr[i]);
    check({tag, ":n_leaf"}, got_base.size(), exp_base.size());
    n = (got_base.size() < exp_base.size()) ? got_base.size() : exp_base.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s:leaf%0d_base", tag, i), got_base[i], exp_base[i]);
      check($sformatf("%s:leaf%0d_cnt", tag, i), got_cnt[i], exp_cnt[i]);
      check($sformatf("%s:leaf%0d_r0", tag, i), got_r0[i], exp_r0[i]);
      check($sformatf("%s:leaf%0d_r1", tag, i), got_r1[i], exp_r1[i]);
    end
  endtask

  initial begin
    int ld, lat, hold, sgn;
    int lat_tab[4] = '{1, 2, 3, 5};
    bus.ray_valid = 1'b0; bus.node_rvalid = 1'b0; bus.leaf_ready = 1'b0;
    set_ray(0, 1, 0, 0); drive_ray(); drive_node(0);
    clear_tree();
    repeat (3) @(posedge clk);
    #1;
    check("rst:ray_ready", bus.ray_ready, 1);
    check("rst:node_req", bus.node_req, 0);
    check("rst:leaf_valid", bus.leaf_valid, 0);
    check("rst:done", bus.done, 0);
    check("rst:overflow", bus.overflow, 0);
    check("rst:data_zero", (bus.isect_box == '0) && (bus.node_addr == '0) && (bus.leaf_range == '0), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    clear_tree(); set_node(0, 1'b0, 1, 5, 6, 0, 0); set_ray(0, 1, 0, 2);
    run_ray(1, 0, "miss", ld);
    check("miss:done_cycle", ld, 6);

    clear_tree(); set_node(0, 1'b1, 0, 1, 3, 7, 2); set_ray(0, 1, 0, 10);
    run_ray(1, 3, "leaf", ld);
    if (got_base.size() > 0) begin
      check("leaf:base7", got_base[0], 7);
      check("leaf:cnt2", got_cnt[0], 2);
      check("leaf:range_lo1", got_r0[0], 1);
      check("leaf:range_hi3", got_r1[0], 3);
    end

    clear_tree();
    set_node(0, 1'b0, 1, 0, 8, 0, 0);
    set_node(1, 1'b1, 0, 1, 3, 11, 1);
    set_node(2, 1'b1, 0, 2, 4, 12, 3);
    set_ray(0, 1, 0, 10);
    run_ray(1, 0, "two", ld);
    run_ray(5, 1, "two_lat5", ld);

    clear_tree();
    set_node(0, 1'b0, 1, 1, 3, 0, 0);
    set_node(1, 1'b0, 3, 1, 3, 0, 0);
    set_node(3, 1'b0, 5, 1, 3, 0, 0);
    set_node(5, 1'b0, 7, 1, 3, 0, 0);
    set_node(2, 1'b1, 0, 1, 3, 20, 1);
    set_node(4, 1'b1, 0, 1, 3, 40, 2);
    set_node(6, 1'b1, 0, 1, 3, 60, 3);
    set_node(7, 1'b1, 0, 1, 3, 70, 4);
    set_node(8, 1'b1, 0, 1, 3, 80, 5);
    set_ray(0, 1, 0, 10);
    run_ray(2, 0, "ovf", ld);
    check("ovf:sticky", bus.overflow, 1);

    clear_tree(); set_node(0, 1'b1, 0, 1, 3, 7, 2); set_ray(0, 1, 0, 10);
    drive_ray();
    bus.ray_valid = 1'b1;
    @(posedge clk); #1;
    bus.ray_valid = 1'b0;
    check("rstw:req", bus.node_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstw:ray_ready", bus.ray_ready, 1);
    check("rstw:node_req", bus.node_req, 0);
    check("rstw:leaf_valid", bus.leaf_valid, 0);
    check("rstw:done", bus.done, 0);
    check("rstw:overflow", bus.overflow, 0);
    rst_n = 1'b1;
    drive_node(0);
    bus.node_rvalid = 1'b1;
    @(posedge clk); #1;
    bus.node_rvalid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("rstw:quiet_done", bus.done, 0);
      check("rstw:quiet_leaf", bus.leaf_valid, 0);
      check("rstw:quiet_req", bus.node_req, 0);
    end

    for (int k = 0; k < 40; k++) begin
      build_tree(int'($urandom_range(0, 5)));
      for (int a = 0; a < 3; a++) begin
        sgn = ($urandom_range(0, 1) == 0) ? -1 : 1;
        r_org[a] = int'($urandom_range(0, 9));
        r_inv[a] = sgn * int'($urandom_range(1, 3));
      end
      r_t0 = int'($urandom_range(0, 25)) - 20;
      r_t1 = r_t0 + int'($urandom_range(0, 40));
      lat  = lat_tab[$urandom_range(0, 3)];
      hold = int'($urandom_range(0, 3)) - 1;
      run_ray(lat, hold, $sformatf("rnd%0d", k), ld);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
